game_end_timer_scorer: RTL and testbench

//  End-of-game timer and score keeper; sits directly downstream of the game master FSM.
//  - Consumes the FSM's timer-start pulse and its game_won flag.
//  - Returns a running flag that holds the FSM in its end state for a fixed delay.
//  - On expiry, records the round result into saturating win/loss counters.
//  - Drives a blink strobe for the display while the delay is running.

---
 rtl/game_end_timer_scorer.sv | 106 ++++++++++
 tb/tb_game_end_timer_scorer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/game_end_timer_scorer.sv
// End-of-game timer and score keeper.
// A start pulse from the game master FSM begins a run that lasts
// PRESCALE*DURATION cycles. While the run is active, running stays high and
// blink toggles once per time unit. When the run expires, expired pulses for
// one cycle and the value of game_won at that edge is added to a saturating
// win or loss counter.
module game_end_timer_scorer #(
   parameter int PRESCALE = 50_000_000,
   parameter int DURATION = 2,
   parameter int SCORE_W  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               game_won,
   input  logic               clear_score,
   output logic               running,
   output logic               expired,
   output logic               blink,
   output logic [SCORE_W-1:0] wins,
   output logic [SCORE_W-1:0] losses
);

   // Counter widths are kept at least 1 bit so that PRESCALE=1 or DURATION=1 stays legal.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int UW = (DURATION > 1) ? $clog2(DURATION) : 1;
   localparam logic [PW-1:0] PRE_LOAD  = PW'(PRESCALE - 1);
   localparam logic [UW-1:0] UNIT_LOAD = UW'(DURATION - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [UW-1:0] unit_cnt;
   logic          expiry_now;

   // Saturating increment: the counter holds at all-ones instead of wrapping.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] cnt);
      if (cnt == {SCORE_W{1'b1}})
         return cnt;
      else
         return cnt + SCORE_W'(1);
   endfunction

   // The last edge of a run: prescaler and unit counter have both reached zero.
   assign expiry_now = (state == RUN) && (presc == '0) && (unit_cnt == '0);

   // Timer FSM: loads the counters on start, counts down, and blinks once per unit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         presc    <= '0;
         unit_cnt <= '0;
         running  <= 1'b0;
         expired  <= 1'b0;
         blink    <= 1'b0;
      end else begin
         expired <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  presc    <= PRE_LOAD;
                  unit_cnt <= UNIT_LOAD;
                  running  <= 1'b1;
                  blink    <= 1'b0;
               end
            end
            RUN: begin
               // start is deliberately ignored in this state, so a run cannot be retriggered.
               if (presc != '0) begin
                  presc <= presc - PW'(1);
               end else if (unit_cnt != '0) begin
                  presc    <= PRE_LOAD;
                  unit_cnt <= unit_cnt - UW'(1);
                  blink    <= ~blink;
               end else begin
                  state   <= IDLE;
                  presc   <= PRE_LOAD;
                  running <= 1'b0;
                  blink   <= 1'b0;
                  expired <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Score counters: a clear wins over the increment for a round ending on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wins   <= '0;
         losses <= '0;
      end else if (clear_score) begin
         wins   <= '0;
         losses <= '0;
      end else if (expiry_now) begin
         if (game_won)
            wins <= sat_inc(wins);
         else
            losses <= sat_inc(losses);
      end
   end

endmodule

// File: tb/tb_game_end_timer_scorer.sv
// Directed bench for game_end_timer_scorer with PRESCALE=4, DURATION=3, SCORE_W=2.
module tb_game_end_timer_scorer;

   localparam int RUN_LEN = 12;

   logic       clk;
   logic       reset;
   logic       start;
   logic       game_won;
   logic       clear_score;
   logic       running;
   logic       expired;
   logic       blink;
   logic [1:0] wins;
   logic [1:0] losses;

   int n_checks = 0;
   int n_pass   = 0;

   game_end_timer_scorer #(
      .PRESCALE(4),
      .DURATION(3),
      .SCORE_W (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .game_won   (game_won),
      .clear_score(clear_score),
      .running    (running),
      .expired    (expired),
      .blink      (blink),
      .wins       (wins),
      .losses     (losses)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if it disagrees.
   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Advance one clock and settle just after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start, then step through the run. At sample k (k=1..) the inputs
   // set here are taken at the following edge; k=12 feeds the expiry edge.
   // game_won is inverted for samples 3..6, so it is back to 'won' at expiry.
   // Returns with the sample just after running falls, and the run length.
   task automatic run_round(input logic won, input int restart_a, input int restart_b,
                            input int clear_at, output int len, output int blink_err);
      start    = 1'b1;
      game_won = won;
      tick();
      start     = 1'b0;
      len       = 0;
      blink_err = 0;
      while (running && len < 200) begin
         len++;
         if (blink != logic'(((len - 1) / 4) % 2)) blink_err++;
         game_won    = (len >= 3 && len <= 6) ? ~won : won;
         start       = (len == restart_a || len == restart_b);
         clear_score = (len == clear_at);
         tick();
      end
      start       = 1'b0;
      clear_score = 1'b0;
      game_won    = won;
   endtask

   initial begin
      int len;
      int berr;
      int bad;

      reset       = 1'b1;
      start       = 1'b0;
      game_won    = 1'b0;
      clear_score = 1'b0;
      tick();
      tick();
      check("reset_running", running, 0);
      check("reset_expired", expired, 0);
      check("reset_blink",   blink,   0);
      check("reset_wins",    wins,    0);
      check("reset_losses",  losses,  0);
      reset = 1'b0;
      tick();

      // Test 1: basic loss
      run_round(1'b0, -1, -1, -1, len, berr);
      check("t1_len",       len,     RUN_LEN);
      check("t1_blink_run", berr,    0);
      check("t1_running",   running, 0);
      check("t1_expired",   expired, 1);
      check("t1_blink_end", blink,   0);
      check("t1_losses",    losses,  1);
      check("t1_wins",      wins,    0);
      tick();
      check("t1_expired_1cyc", expired, 0);

      // Test 2: win with game_won wobbling mid-run
      run_round(1'b1, -1, -1, -1, len, berr);
      check("t2_len",    len,     RUN_LEN);
      check("t2_expired", expired, 1);
      check("t2_wins",   wins,    1);
      check("t2_losses", losses,  1);
      tick();

      // Test 3: starts at cycle 5 and on the expiry edge are ignored
      run_round(1'b0, 5, RUN_LEN, -1, len, berr);
      check("t3_len",     len,     RUN_LEN);
      check("t3_expired", expired, 1);
      check("t3_losses",  losses,  2);
      // start while expired is high launches a fresh run
      run_round(1'b0, -1, -1, -1, len, berr);
      check("t3_b2b_len",    len,    RUN_LEN);
      check("t3_b2b_losses", losses, 3);
      tick();
      check("t3_idle_running", running, 0);

      // Test 4: saturation of wins
      clear_score = 1'b1;
      tick();
      clear_score = 1'b0;
      check("t4_clr_wins",   wins,   0);
      check("t4_clr_losses", losses, 0);
      for (int r = 1; r <= 5; r++) begin
         run_round(1'b1, -1, -1, -1, len, berr);
         check($sformatf("t4_wins_r%0d", r), wins, (r < 3) ? r : 3);
         tick();
      end
      check("t4_losses", losses, 0);

      // Test 5: clear on the expiry edge beats the increment
      run_round(1'b1, -1, -1, RUN_LEN, len, berr);
      check("t5_len",     len,     RUN_LEN);
      check("t5_expired", expired, 1);
      check("t5_wins",    wins,    0);
      check("t5_losses",  losses,  0);
      tick();

      // Test 6: asynchronous reset at cycle 6 of a run
      start    = 1'b1;
      game_won = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k < 6; k++) tick();
      check("t6_running_pre", running, 1);
      #2;
      reset = 1'b1;
      #1;
      check("t6_running_async", running, 0);
      check("t6_blink_async",   blink,   0);
      tick();
      tick();
      #3;
      reset = 1'b0;
      bad = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (expired || running) bad++;
      end
      check("t6_no_pulse", bad,    0);
      check("t6_wins",     wins,   0);
      check("t6_losses",   losses, 0);
      run_round(1'b1, -1, -1, -1, len, berr);
      check("t6_len",      len,     RUN_LEN);
      check("t6_expired",  expired, 1);
      check("t6_wins_after", wins,  1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
